// File: rtl/accu_ctrl_pkg.sv
// Shared constants for the accumulator machine: opcodes, ALU select codes and
// controller state encoding, used by both the control unit and the datapath.
package accu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_NOR  = 3'b000,
        OP_ADD  = 3'b001,
        OP_STA  = 3'b010,
        OP_JCC  = 3'b011,
        OP_LDA  = 3'b100,
        OP_SUB  = 3'b101,
        OP_JMP  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    localparam logic [2:0] SEL_LDA = 3'b000;
    localparam logic [2:0] SEL_NOR = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_SUB = 3'b011;

    typedef enum logic [2:0] {
        ST_BOOT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_OPER   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_ALU    = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Opcodes without an ALU function fall back to the pass-through select.
    function automatic logic [2:0] alu_sel(input opcode_e op);
        case (op)
            OP_NOR:  return SEL_NOR;
            OP_ADD:  return SEL_ADD;
            OP_SUB:  return SEL_SUB;
            default: return SEL_LDA;
        endcase
    endfunction

endpackage

// File: rtl/accu_ctrl_if.sv
// Control-unit bus: run controls and carry from the datapath, memory read data,
// and the address/strobe/status outputs of the controller.
interface accu_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              ce;
    logic              boot;
    logic              carry;
    logic [DATA_W-1:0] data_in;
    logic [ADDR_W-1:0] adr;
    logic              enable_mem;
    logic              w_mem;
    logic              load_R1;
    logic              load_accu;
    logic              load_carry;
    logic              clear_carry;
    logic              halted;
    logic [2:0]        sel_UAL;

    modport master (
        input  ce, boot, carry, data_in,
        output adr, enable_mem, w_mem, load_R1, load_accu, load_carry,
               clear_carry, halted, sel_UAL
    );

    modport slave (
        output ce, boot, carry, data_in,
        input  adr, enable_mem, w_mem, load_R1, load_accu, load_carry,
               clear_carry, halted, sel_UAL
    );
endinterface

// File: rtl/accu_ctrl_pc.sv
// Program counter with prioritised clear, load, increment and hold.
// Increment wraps naturally modulo 2^ADDR_W.
module accu_ctrl_pc #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic              inc_i,
    input  logic [ADDR_W-1:0] load_val_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (clear_i) begin
            pc_d = '0;
        end else if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/accu_ctrl_unit.sv
// Control unit of the accumulator machine: sequences fetch/decode/operand/ALU
// cycles and drives the memory and datapath strobes from state and IR.
module accu_ctrl_unit #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    accu_ctrl_if.master bus
);
    import accu_ctrl_pkg::*;

    if (DATA_W < 3 + ADDR_W) begin : g_bad_width
        $error("accu_ctrl_unit: DATA_W must be at least 3+ADDR_W");
    end

    // Only the opcode and address fields of an instruction are kept.
    localparam int IR_W = 3 + ADDR_W;

    state_e            state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    opcode_e           ir_op, in_op;
    logic [ADDR_W-1:0] ir_adr, in_adr, pc;
    logic              pc_clear, pc_load, pc_inc;
    logic              active;
    logic              em_c, wm_c, r1_c, la_c, lc_c, cc_c;
    logic [ADDR_W-1:0] adr_c;
    logic [2:0]        sel_c;

    assign in_op  = opcode_e'(bus.data_in[DATA_W-1 -: 3]);
    assign in_adr = bus.data_in[ADDR_W-1:0];
    assign ir_op  = opcode_e'(ir_q[IR_W-1 -: 3]);
    assign ir_adr = ir_q[ADDR_W-1:0];
    assign active = bus.ce & ~bus.boot;

    accu_ctrl_pc #(.ADDR_W(ADDR_W)) u_pc (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (pc_clear),
        .load_i     (pc_load),
        .inc_i      (pc_inc),
        .load_val_i (in_adr),
        .pc_o       (pc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // Decode the JCC/JMP branch from the incoming word, since IR is only loaded
    // at the end of DECODE.
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        pc_clear = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        em_c     = 1'b0;
        wm_c     = 1'b0;
        r1_c     = 1'b0;
        la_c     = 1'b0;
        lc_c     = 1'b0;
        cc_c     = 1'b0;
        sel_c    = SEL_LDA;
        adr_c    = pc;

        case (state_q)
            ST_BOOT: begin
                adr_c    = '0;
                pc_clear = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_FETCH: begin
                em_c    = 1'b1;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                ir_d   = {bus.data_in[DATA_W-1 -: 3], in_adr};
                pc_inc = 1'b1;
                case (in_op)
                    OP_JMP: begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end
                    OP_JCC: begin
                        pc_load = ~bus.carry;
                        cc_c    = bus.carry;
                        state_d = ST_FETCH;
                    end
                    OP_HALT: state_d = ST_HALT;
                    default: state_d = ST_OPER;
                endcase
            end
            ST_OPER: begin
                adr_c = ir_adr;
                em_c  = 1'b1;
                if (ir_op == OP_STA) begin
                    wm_c    = 1'b1;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                adr_c   = ir_adr;
                r1_c    = 1'b1;
                state_d = ST_ALU;
            end
            ST_ALU: begin
                adr_c   = ir_adr;
                sel_c   = alu_sel(ir_op);
                la_c    = 1'b1;
                lc_c    = (ir_op == OP_ADD) || (ir_op == OP_SUB);
                state_d = ST_FETCH;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase

        if (!bus.ce) begin
            state_d  = state_q;
            ir_d     = ir_q;
            pc_clear = 1'b0;
            pc_load  = 1'b0;
            pc_inc   = 1'b0;
        end
        if (bus.boot) begin
            state_d  = ST_BOOT;
            ir_d     = ir_q;
            pc_clear = 1'b1;
            pc_load  = 1'b0;
            pc_inc   = 1'b0;
        end
    end

    // A stall or boot request suppresses every strobe of the current state.
    assign bus.enable_mem  = em_c & active;
    assign bus.w_mem       = wm_c & active;
    assign bus.load_R1     = r1_c & active;
    assign bus.load_accu   = la_c & active;
    assign bus.load_carry  = lc_c & active;
    assign bus.clear_carry = cc_c & active;
    assign bus.adr         = adr_c;
    assign bus.sel_UAL     = sel_c;
    assign bus.halted      = (state_q == ST_HALT);

endmodule
